// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
    logic [31:0] instruction;
    logic        zero_flag;
    logic        mem_ready;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  nPC_sel;
    logic        regDst;
    logic        aluSrc;
    logic [1:0]  aluCtr;
    logic        extOp;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
    logic        isJal;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instruction, zero_flag, mem_ready,
        output irWrite, pcWrite, nPC_sel, regDst, aluSrc, aluCtr, extOp,
               memRead, memWrite, memToReg, regWrite, isJal, illegal, state
    );

    modport slave (
        output instruction, zero_flag, mem_ready,
        input  irWrite, pcWrite, nPC_sel, regDst, aluSrc, aluCtr, extOp,
               memRead, memWrite, memToReg, regWrite, isJal, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define MCTRL_MEM_WAIT_EN to make MEM wait on mem_ready; otherwise MEM is a single cycle.
module multicycle_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_if.master     ctrl
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        I_ILL  = 3'd0,
        I_ADDU = 3'd1,
        I_SUBU = 3'd2,
        I_ORI  = 3'd3,
        I_LW   = 3'd4,
        I_SW   = 3'd5,
        I_BEQ  = 3'd6,
        I_JAL  = 3'd7
    } instr_e;

    function automatic instr_e classify(input logic [5:0] op, input logic [5:0] funct);
        instr_e kind;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: kind = I_ADDU;
                    6'b100011: kind = I_SUBU;
                    default:   kind = I_ILL;
                endcase
            end
            6'b001101: kind = I_ORI;
            6'b100011: kind = I_LW;
            6'b101011: kind = I_SW;
            6'b000100: kind = I_BEQ;
            6'b000011: kind = I_JAL;
            default:   kind = I_ILL;
        endcase
        return kind;
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  funct_q, funct_d;
    instr_e      instr_s;
    logic        mem_done_s;

    logic        ir_write_s, pc_write_s, reg_dst_s, alu_src_s, ext_op_s;
    logic        mem_read_s, mem_write_s, mem_to_reg_s, reg_write_s, is_jal_s, illegal_s;
    logic [1:0]  npc_sel_s, alu_ctr_s;

    // Branch resolution lives in the fetch unit; these inputs are intentionally not consumed here.
    logic        unused_s;
    assign unused_s = ^{ctrl.zero_flag, ctrl.mem_ready, ctrl.instruction[25:6]};

    assign instr_s = classify(op_q, funct_q);

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_done_s = ctrl.mem_ready;
`else
    assign mem_done_s = 1'b1;
`endif

    // State and latched opcode/funct registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state and output decode from state plus latched opcode/funct only.
    always_comb begin
        state_d      = S_FETCH;
        op_d         = op_q;
        funct_d      = funct_q;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        npc_sel_s    = 2'b00;
        reg_dst_s    = 1'b0;
        alu_src_s    = 1'b0;
        alu_ctr_s    = 2'b00;
        ext_op_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        is_jal_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                op_d       = ctrl.instruction[31:26];
                funct_d    = ctrl.instruction[5:0];
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                case (instr_s)
                    I_JAL: begin
                        pc_write_s  = 1'b1;
                        npc_sel_s   = 2'b10;
                        reg_write_s = 1'b1;
                        is_jal_s    = 1'b1;
                        state_d     = S_FETCH;
                    end
                    I_ILL: begin
                        illegal_s  = 1'b1;
                        pc_write_s = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (instr_s)
                    I_ADDU: state_d = S_WB;
                    I_SUBU: begin
                        alu_ctr_s = 2'b01;
                        state_d   = S_WB;
                    end
                    I_ORI: begin
                        alu_ctr_s = 2'b10;
                        alu_src_s = 1'b1;
                        state_d   = S_WB;
                    end
                    I_LW, I_SW: begin
                        alu_src_s = 1'b1;
                        ext_op_s  = 1'b1;
                        state_d   = S_MEM;
                    end
                    I_BEQ: begin
                        alu_ctr_s  = 2'b01;
                        pc_write_s = 1'b1;
                        npc_sel_s  = 2'b01;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                alu_src_s   = 1'b1;
                ext_op_s    = 1'b1;
                mem_read_s  = (instr_s == I_LW);
                mem_write_s = (instr_s == I_SW);
                if (!mem_done_s) begin
                    state_d = S_MEM;
                end else if (instr_s == I_LW) begin
                    state_d = S_WB;
                end else begin
                    pc_write_s = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                reg_dst_s    = (instr_s == I_ADDU) || (instr_s == I_SUBU);
                mem_to_reg_s = (instr_s == I_LW);
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign ctrl.irWrite  = ir_write_s;
    assign ctrl.pcWrite  = pc_write_s;
    assign ctrl.nPC_sel  = npc_sel_s;
    assign ctrl.regDst   = reg_dst_s;
    assign ctrl.aluSrc   = alu_src_s;
    assign ctrl.aluCtr   = alu_ctr_s;
    assign ctrl.extOp    = ext_op_s;
    assign ctrl.memRead  = mem_read_s;
    assign ctrl.memWrite = mem_write_s;
    assign ctrl.memToReg = mem_to_reg_s;
    assign ctrl.regWrite = reg_write_s;
    assign ctrl.isJal    = is_jal_s;
    assign ctrl.illegal  = illegal_s;
    assign ctrl.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written reset and wait-state sequences.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    always #5 clk = ~clk;

    // {irWrite, pcWrite, nPC_sel, regDst, aluSrc, aluCtr, extOp, memRead, memWrite, memToReg, regWrite, isJal, illegal}
    localparam logic [14:0] IR   = 15'h4000;
    localparam logic [14:0] PC   = 15'h2000;
    localparam logic [14:0] NJAL = 15'h1000;
    localparam logic [14:0] NBEQ = 15'h0800;
    localparam logic [14:0] RD   = 15'h0400;
    localparam logic [14:0] AS   = 15'h0200;
    localparam logic [14:0] AOR  = 15'h0100;
    localparam logic [14:0] ASUB = 15'h0080;
    localparam logic [14:0] EX   = 15'h0040;
    localparam logic [14:0] MR   = 15'h0020;
    localparam logic [14:0] MW   = 15'h0010;
    localparam logic [14:0] M2R  = 15'h0008;
    localparam logic [14:0] RW   = 15'h0004;
    localparam logic [14:0] JAL  = 15'h0002;
    localparam logic [14:0] ILL  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    localparam logic [31:0] ADDU_I = 32'h0022_1821;
    localparam logic [31:0] SUBU_I = 32'h0022_1823;
    localparam logic [31:0] ORI_I  = 32'h3422_0005;
    localparam logic [31:0] LW_I   = 32'h8C22_0004;
    localparam logic [31:0] SW_I   = 32'hAC22_0008;
    localparam logic [31:0] BEQ_I  = 32'h1022_0003;
    localparam logic [31:0] JAL_I  = 32'h0C00_0010;
    localparam logic [31:0] BAD_OP = 32'hFC00_0000;
    localparam logic [31:0] BAD_FN = 32'h0000_0020;
    localparam logic [31:0] JUNK   = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  st;
        logic [14:0] out;
    } vec_t;

    vec_t vq[$];

    logic [14:0] out_s;
    assign out_s = {bus.irWrite, bus.pcWrite, bus.nPC_sel, bus.regDst, bus.aluSrc, bus.aluCtr,
                    bus.extOp, bus.memRead, bus.memWrite, bus.memToReg, bus.regWrite, bus.isJal,
                    bus.illegal};

    int lat, mr_cnt, mw_cnt, pc_cnt, rw_cnt, m2r_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic [2:0] s, input logic [14:0] o);
        vec_t v;
        v.instr = i;
        v.st    = s;
        v.out   = o;
        vq.push_back(v);
    endtask

    // Runs one instruction from a FETCH negedge back to the next FETCH, counting strobes.
    task automatic measure(input logic [31:0] ins, input int waits);
        int mem_idx;
        mem_idx = 0;
        lat = 0; mr_cnt = 0; mw_cnt = 0; pc_cnt = 0; rw_cnt = 0; m2r_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            bus.instruction = ins;
            bus.mem_ready   = (bus.state == 3'd3) && (mem_idx >= waits);
            #1;
            mr_cnt  += int'(bus.memRead);
            mw_cnt  += int'(bus.memWrite);
            pc_cnt  += int'(bus.pcWrite);
            rw_cnt  += int'(bus.regWrite);
            m2r_cnt += int'(bus.memToReg);
            if (bus.state == 3'd3) mem_idx++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.state == 3'd0) break;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.instruction = 32'd0;
        bus.zero_flag   = 1'b0;
        bus.mem_ready   = 1'b1;

        // ori: FETCH, DECODE (instruction changed, must be ignored), EXEC, WB
        add(ORI_I,  3'd0, IR);
        add(JUNK,   3'd1, NONE);
        add(JUNK,   3'd2, AOR | AS);
        add(JUNK,   3'd4, RW | PC);
        add(ADDU_I, 3'd0, IR);
        add(ADDU_I, 3'd1, NONE);
        add(ADDU_I, 3'd2, NONE);
        add(ADDU_I, 3'd4, RW | PC | RD);
        add(SUBU_I, 3'd0, IR);
        add(SUBU_I, 3'd1, NONE);
        add(SUBU_I, 3'd2, ASUB);
        add(SUBU_I, 3'd4, RW | PC | RD);
        add(SW_I,   3'd0, IR);
        add(SW_I,   3'd1, NONE);
        add(SW_I,   3'd2, AS | EX);
        add(SW_I,   3'd3, AS | EX | MW | PC);
        add(BEQ_I,  3'd0, IR);
        add(BEQ_I,  3'd1, NONE);
        add(BEQ_I,  3'd2, ASUB | PC | NBEQ);
        add(JAL_I,  3'd0, IR);
        add(JAL_I,  3'd1, PC | NJAL | RW | JAL);
        add(BAD_OP, 3'd0, IR);
        add(BAD_OP, 3'd1, ILL | PC);
        add(BAD_FN, 3'd0, IR);
        add(BAD_FN, 3'd1, ILL | PC);
        add(LW_I,   3'd0, IR);
        add(LW_I,   3'd1, NONE);
        add(LW_I,   3'd2, AS | EX);
        add(LW_I,   3'd3, AS | EX | MR);
        add(LW_I,   3'd4, RW | PC | M2R);

        repeat (2) @(negedge clk);
        #1;
        check("reset_state_out", {29'd0, bus.state, out_s}, {29'd0, 3'd0, IR});
        rst = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            bus.instruction = vq[k].instr;
            bus.mem_ready   = 1'b1;
            #1;
            check($sformatf("vec%0d", k), {14'd0, bus.state, out_s}, {14'd0, vq[k].st, vq[k].out});
            @(negedge clk);
        end
        check("after_table_fetch", {29'd0, bus.state}, 32'd0);

        // Reset in the middle of WB for addu
        bus.instruction = ADDU_I;
        repeat (3) @(negedge clk);
        #1;
        check("addu_in_wb", {29'd0, bus.state}, 32'd4);
        rst = 1'b1;
        #1;
        check("rst_wb_immediate", {14'd0, bus.state, out_s}, {14'd0, 3'd0, IR});
        @(posedge clk);
        #1;
        check("rst_wb_no_regwrite", {31'd0, bus.regWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_fetch", {29'd0, bus.state}, 32'd0);
        @(negedge clk);
        check("rst_release_decode", {29'd0, bus.state}, 32'd1);
        repeat (3) @(negedge clk);
        check("addu_rerun_fetch", {29'd0, bus.state}, 32'd0);

        // Reset while sw sits in MEM with the memory not ready
        bus.instruction = SW_I;
        bus.mem_ready   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sw_mem_active", {28'd0, bus.state, bus.memWrite}, {28'd0, 3'd3, 1'b1});
        rst = 1'b1;
        #1;
        check("rst_mem_drop", {27'd0, bus.state, bus.memRead, bus.memWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_release", {29'd0, bus.state}, 32'd0);

        // lw with mem_ready held low for two MEM cycles
        measure(LW_I, 2);
`ifdef MCTRL_MEM_WAIT_EN
        check("lw_wait_latency", lat, 7);
        check("lw_wait_memread", mr_cnt, 3);
`else
        check("lw_wait_latency", lat, 5);
        check("lw_wait_memread", mr_cnt, 1);
`endif
        check("lw_wait_memtoreg", m2r_cnt, 1);
        check("lw_wait_regwrite", rw_cnt, 1);
        check("lw_wait_pcwrite", pc_cnt, 1);
        check("lw_wait_memwrite", mw_cnt, 0);

        // sw with mem_ready held low for two MEM cycles
        measure(SW_I, 2);
`ifdef MCTRL_MEM_WAIT_EN
        check("sw_wait_latency", lat, 6);
        check("sw_wait_memwrite", mw_cnt, 3);
`else
        check("sw_wait_latency", lat, 4);
        check("sw_wait_memwrite", mw_cnt, 1);
`endif
        check("sw_wait_regwrite", rw_cnt, 0);
        check("sw_wait_pcwrite", pc_cnt, 1);

        // sw with mem_ready=1, and jal/beq/addu latencies
        measure(SW_I, 0);
        check("sw_latency", lat, 4);
        check("sw_memwrite", mw_cnt, 1);
        check("sw_regwrite", rw_cnt, 0);
        measure(JAL_I, 0);
        check("jal_latency", lat, 2);
        check("jal_regwrite", rw_cnt, 1);
        measure(BEQ_I, 0);
        check("beq_latency", lat, 3);
        check("beq_regwrite", rw_cnt, 0);
        measure(ADDU_I, 0);
        check("addu_latency", lat, 4);
        check("addu_pcwrite", pc_cnt, 1);
        measure(BAD_OP, 0);
        check("illegal_latency", lat, 2);
        check("illegal_writes", rw_cnt + mw_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
